// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: busy-bit scoreboard for issue hazards plus a
// two-requester round-robin writeback arbiter feeding a registered RF write port.
module rf_wb_scheduler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_addr,
    input  logic [31:0] wb0_data,
    output logic        wb0_ready,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_addr,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] busy_vec,
    output logic        err_orphan
);

    logic [31:0] r_busy;
    logic        r_last_gnt1;
    logic        r_we_p1;
    logic [4:0]  r_wa_p1;
    logic [31:0] r_wd_p1;
    logic        r_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt_any;
    logic [4:0]  w_gnt_addr;
    logic [31:0] w_gnt_data;
    logic        w_gnt_write;
    logic        w_orphan;
    logic        w_iss_acc;
    logic [31:0] w_busy_nxt;

    // Hazard check covers RAW on both sources and WAW on the destination.
    assign iss_stall = iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd]);
    assign w_iss_acc = iss_valid & ~iss_stall;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign w_gnt0     = wb0_valid & (~wb1_valid | r_last_gnt1);
    assign w_gnt1     = wb1_valid & (~wb0_valid | ~r_last_gnt1);
    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign wb0_ready  = rstn & w_gnt0;
    assign wb1_ready  = rstn & w_gnt1;

    assign w_gnt_addr  = w_gnt1 ? wb1_addr : wb0_addr;
    assign w_gnt_data  = w_gnt1 ? wb1_data : wb0_data;
    assign w_gnt_write = w_gnt_any & (w_gnt_addr != 5'd0);
    assign w_orphan    = w_gnt_write & ~r_busy[w_gnt_addr];

    // Commit clears first so a same-edge reservation of the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we_p1)
            w_busy_nxt[r_wa_p1] = 1'b0;
        if (w_iss_acc && (iss_rd != 5'd0))
            w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy      <= 32'd0;
            r_last_gnt1 <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_gnt_any)
                r_last_gnt1 <= w_gnt1;
            if (w_orphan)
                r_err <= 1'b1;
        end
    end

    // p1: granted writeback presented to the register file one cycle after grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we_p1 <= 1'b0;
            r_wa_p1 <= 5'd0;
            r_wd_p1 <= 32'd0;
        end else begin
            r_we_p1 <= w_gnt_write;
            if (w_gnt_write) begin
                r_wa_p1 <= w_gnt_addr;
                r_wd_p1 <= w_gnt_data;
            end
        end
    end

    assign rf_we      = r_we_p1;
    assign rf_wa      = r_wa_p1;
    assign rf_wd      = r_wd_p1;
    assign busy_vec   = r_busy;
    assign err_orphan = r_err;

endmodule
